// File: rtl/bcd_seg_display_if.sv
// Handshake and display bus between the upstream counter/hold/add stage,
// the BCD display block and the physical 7-segment pins.
interface bcd_seg_display_if;
    logic [3:0] din;
    logic       load;
    logic       busy;
    logic       valid;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output din, load,
        input  busy, valid, tens, ones, seg, an
    );

    modport slave (
        input  din, load,
        output busy, valid, tens, ones, seg, an
    );
endinterface

// File: rtl/bcd_seg_display.sv
// Converts a 4-bit value to two BCD digits with a sequential double-dabble.
// It also drives a 2-digit multiplexed 7-segment display.
module bcd_seg_display #(
    parameter int SCAN_DIV     = 4,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    bcd_seg_display_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int SCAN_W = $clog2(SCAN_DIV);

    state_t             state_q, state_d;
    logic [11:0]        sr_q, sr_d, sr_adj;
    logic [1:0]         bit_cnt_q, bit_cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic               dsel_q, dsel_d;
    logic [6:0]         seg_raw;
    logic [1:0]         an_raw;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Register layout: [11:8] BCD tens, [7:4] BCD ones, [3:0] binary input.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        valid_d   = 1'b0;
        sr_adj    = {dabble(sr_q[11:8]), dabble(sr_q[7:4]), sr_q[3:0]};
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sr_d      = {8'd0, bus.din};
                    bit_cnt_d = 2'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_d      = sr_adj << 1;
                bit_cnt_d = bit_cnt_q + 2'd1;
                if (bit_cnt_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                tens_d  = sr_q[11:8];
                ones_d  = sr_q[7:4];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        dsel_d = dsel_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            dsel_d = ~dsel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            tens_q    <= '0;
            ones_q    <= '0;
            scan_q    <= '0;
            dsel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            scan_q    <= scan_d;
            dsel_q    <= dsel_d;
        end
    end

    // Tens digit is blanked when zero so single-digit values show one digit.
    always_comb begin
        if (!dsel_q) begin
            an_raw  = 2'b01;
            seg_raw = encode(ones_q);
        end else begin
            an_raw  = 2'b10;
            seg_raw = (tens_q == 4'd0) ? 7'b0000000 : encode(tens_q);
        end
    end

    assign bus.seg   = seg_raw ^ {7{COMMON_ANODE}};
    assign bus.an    = an_raw ^ {2{COMMON_ANODE}};
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.tens  = tens_q;
    assign bus.ones  = ones_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench for bcd_seg_display: conversions, handshake, scan timing,
// common-anode polarity and asynchronous reset.
module tb_bcd_seg_display;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    bcd_seg_display_if bus ();
    bcd_seg_display_if bus2 ();

    bcd_seg_display #(.SCAN_DIV(4), .COMMON_ANODE(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bcd_seg_display #(.SCAN_DIV(4), .COMMON_ANODE(1'b1)) dut_ca (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Common-anode twin never converts, so it always shows 0 (ones) / blank (tens).
    task automatic chk_ca(input string tag);
        logic [1:0] an_inv;
        logic [6:0] seg_exp;
        an_inv  = ~bus.an;
        seg_exp = (bus.an == 2'b01) ? 7'b0000001 : 7'b1111111;
        chk({tag, "_ca_an"}, bus2.an, an_inv);
        chk({tag, "_ca_seg"}, bus2.seg, seg_exp);
    endtask

    task automatic wait_an(input string tag, input logic [1:0] target, input logic [6:0] seg_exp);
        for (int i = 0; i < 12 && bus.an !== target; i++) tick();
        chk({tag, "_an"}, bus.an, target);
        chk({tag, "_seg"}, bus.seg, seg_exp);
    endtask

    // Drives one conversion from IDLE; returns with the bench sampled just after the valid cycle.
    task automatic convert(input string tag, input logic [3:0] d, input logic [3:0] et, input logic [3:0] eo);
        bus.din  = d;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.din  = ~d;
        for (int i = 0; i < 5; i++) begin
            chk({tag, "_busy"}, bus.busy, 1'b1);
            chk({tag, "_novalid"}, bus.valid, 1'b0);
            tick();
        end
        chk({tag, "_busy_end"}, bus.busy, 1'b0);
        chk({tag, "_valid"}, bus.valid, 1'b1);
        chk({tag, "_tens"}, bus.tens, et);
        chk({tag, "_ones"}, bus.ones, eo);
        tick();
        chk({tag, "_valid_end"}, bus.valid, 1'b0);
    endtask

    task automatic scan_check(input string tag, input int periods);
        logic [1:0] cur;
        logic [1:0] inv;
        cur = bus.an;
        for (int i = 0; i < 12 && bus.an === cur; i++) tick();
        inv = ~cur;
        chk({tag, "_first_flip"}, bus.an, inv);
        cur = bus.an;
        for (int p = 0; p < periods; p++) begin
            for (int k = 1; k < 4; k++) begin
                tick();
                chk({tag, "_hold"}, bus.an, cur);
                chk_ca(tag);
            end
            tick();
            inv = ~cur;
            chk({tag, "_flip"}, bus.an, inv);
            cur = bus.an;
        end
    endtask

    initial begin
        bus.din   = 4'd0;
        bus.load  = 1'b0;
        bus2.din  = 4'd0;
        bus2.load = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_tens", bus.tens, 4'd0);
        chk("rst_ones", bus.ones, 4'd0);
        chk("rst_an", bus.an, 2'b01);
        chk("rst_seg", bus.seg, 7'b1111110);
        chk("rst_ca_an", bus2.an, 2'b10);
        chk("rst_ca_seg", bus2.seg, 7'b0000001);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_novalid", bus.valid, 1'b0);
        end

        convert("c7", 4'd7, 4'd0, 4'd7);
        wait_an("c7_ones", 2'b01, 7'b1110000);
        wait_an("c7_tens", 2'b10, 7'b0000000);

        convert("c9", 4'd9, 4'd0, 4'd9);
        wait_an("c9_ones", 2'b01, 7'b1111011);
        convert("c4", 4'd4, 4'd0, 4'd4);
        wait_an("c4_ones", 2'b01, 7'b0110011);
        convert("c15", 4'd15, 4'd1, 4'd5);
        wait_an("c15_tens", 2'b10, 7'b0110000);
        wait_an("c15_ones", 2'b01, 7'b1011011);
        convert("c0", 4'd0, 4'd0, 4'd0);
        wait_an("c0_ones", 2'b01, 7'b1111110);
        wait_an("c0_tens", 2'b10, 7'b0000000);

        // Second load two cycles in is dropped; the next one lands on the valid cycle
        bus.din  = 4'd3;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        bus.din  = 4'd12;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("lb_novalid", bus.valid, 1'b0);
            tick();
        end
        chk("lb_novalid", bus.valid, 1'b0);
        tick();
        chk("lb_valid1", bus.valid, 1'b1);
        chk("lb_tens", bus.tens, 4'd0);
        chk("lb_ones", bus.ones, 4'd3);
        bus.din  = 4'd12;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk("b2b_busy", bus.busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("b2b_novalid", bus.valid, 1'b0);
            tick();
        end
        chk("b2b_valid2", bus.valid, 1'b1);
        chk("b2b_tens", bus.tens, 4'd1);
        chk("b2b_ones", bus.ones, 4'd2);
        tick();
        chk("b2b_valid_end", bus.valid, 1'b0);

        scan_check("scan_idle", 3);
        bus.din  = 4'd5;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        scan_check("scan_conv", 3);
        chk("scan_conv_ones", bus.ones, 4'd5);

        // Reset lands between edges N+2 and N+3 of a din=15 conversion
        bus.din  = 4'd15;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_valid", bus.valid, 1'b0);
        chk("mid_tens", bus.tens, 4'd0);
        chk("mid_ones", bus.ones, 4'd0);
        chk("mid_an", bus.an, 2'b01);
        chk("mid_seg", bus.seg, 7'b1111110);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_novalid", bus.valid, 1'b0);
        end
        chk("mid_tens_after", bus.tens, 4'd0);
        chk("mid_ones_after", bus.ones, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
